// File: rtl/fir_pkg.sv
// Shared state encoding, default width and index-width helper for the FIR sequencer slice.
package fir_pkg;

  localparam int FIR_N = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_OUTPUT,
    ST_FLUSH
  } fir_seq_state_t;

  // Bits needed to hold any value 0..n, so an index equal to n (out of range) stays expressible.
  function automatic int fir_clog2(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient banks: shadow written any time, copied to active on i_apply.
// Active values only move on i_apply, so the chain sees stable coefficients between commits.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int N    = FIR_N,
  parameter int TAPS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_wr,
  input  logic [fir_clog2(TAPS)-1:0]  i_addr,
  input  logic [N-1:0]                i_data,
  input  logic                        i_commit,
  input  logic                        i_apply,
  output logic                        o_pending,
  output logic                        o_pending_nxt,
  output logic [TAPS*N-1:0]           o_chain_b
);

  logic r_pending;
  logic w_wr_ok;

  assign w_wr_ok       = i_wr && (int'(i_addr) < TAPS);
  // A commit arriving during the apply cycle is merged: the copy already sees this cycle's write.
  assign o_pending_nxt = (r_pending || i_commit) && !i_apply;
  assign o_pending     = r_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= 1'b0;
    else      r_pending <= o_pending_nxt;
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic         w_hit;
    logic [N-1:0] r_shadow;
    logic [N-1:0] r_active;

    assign w_hit = w_wr_ok && (int'(i_addr) == k);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        if (w_hit)   r_shadow <= i_data;
        if (i_apply) r_active <= w_hit ? i_data : r_shadow;
      end
    end

    assign o_chain_b[k*N +: N] = r_active;
  end

endmodule

// File: rtl/fir_sequencer.sv
// Sequences a tapped-delay FIR chain: accept sample, settle, capture sum, hold result until m_ready.
// Accept to m_valid is SETTLE+2 cycles; s_ready drops while busy or a commit/flush is pending.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int N      = FIR_N,
  parameter int TAPS   = 8,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [N-1:0]                s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [N-1:0]                m_data,
  input  logic                        coef_wr,
  input  logic [fir_clog2(TAPS)-1:0]  coef_addr,
  input  logic [N-1:0]                coef_data,
  input  logic                        coef_commit,
  output logic                        coef_pending,
  input  logic                        flush,
  output logic [N-1:0]                chain_x,
  output logic                        chain_ena,
  output logic [TAPS*N-1:0]           chain_b,
  input  logic [N-1:0]                chain_y
);

  localparam int CW = fir_clog2((SETTLE > TAPS) ? SETTLE : TAPS);

  fir_seq_state_t r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_chain_x;
  logic [N-1:0]   r_m_data;
  logic           r_chain_ena;
  logic           r_m_valid;
  logic           r_s_ready;
  logic           r_flush_pend;

  logic w_pending;
  logic w_pending_nxt;
  logic w_idle;
  logic w_apply;
  logic w_flush_start;
  logic w_accept;
  logic w_flush_pend_nxt;
  logic w_idle_rdy;

  // IDLE priority: pending commit, then pending flush, then a new sample.
  assign w_idle           = (r_state == ST_IDLE);
  assign w_apply          = w_idle && w_pending;
  assign w_flush_start    = w_idle && !w_pending && r_flush_pend;
  assign w_accept         = w_idle && !w_pending && !r_flush_pend && r_s_ready && s_valid;
  assign w_flush_pend_nxt = (r_flush_pend || flush) && !w_flush_start;
  assign w_idle_rdy       = !w_pending_nxt && !w_flush_pend_nxt;

  fir_coeff_bank #(
    .N    (N),
    .TAPS (TAPS)
  ) u_bank (
    .clk           (clk),
    .rst           (rst),
    .i_wr          (coef_wr),
    .i_addr        (coef_addr),
    .i_data        (coef_data),
    .i_commit      (coef_commit),
    .i_apply       (w_apply),
    .o_pending     (w_pending),
    .o_pending_nxt (w_pending_nxt),
    .o_chain_b     (chain_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_chain_x    <= '0;
      r_m_data     <= '0;
      r_chain_ena  <= 1'b0;
      r_m_valid    <= 1'b0;
      r_s_ready    <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_flush_pend <= w_flush_pend_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_flush_start) begin
            r_state     <= ST_FLUSH;
            r_chain_x   <= '0;
            r_chain_ena <= 1'b1;
            r_cnt       <= CW'(TAPS - 1);
            r_s_ready   <= 1'b0;
          end else if (w_accept) begin
            r_state   <= ST_SETTLE;
            r_chain_x <= s_data;
            r_cnt     <= CW'(SETTLE - 1);
            r_s_ready <= 1'b0;
          end else begin
            r_s_ready <= w_idle_rdy;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state     <= ST_CAPTURE;
            r_chain_ena <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_CAPTURE: begin
          // Sum is sampled on the same edge that shifts the chain.
          r_state     <= ST_OUTPUT;
          r_chain_ena <= 1'b0;
          r_m_data    <= chain_y;
          r_m_valid   <= 1'b1;
        end
        ST_OUTPUT: begin
          if (m_ready) begin
            r_state   <= ST_IDLE;
            r_m_valid <= 1'b0;
            r_s_ready <= w_idle_rdy;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == '0) begin
            r_state     <= ST_IDLE;
            r_chain_ena <= 1'b0;
            r_s_ready   <= w_idle_rdy;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign m_valid      = r_m_valid;
  assign m_data       = r_m_data;
  assign chain_x      = r_chain_x;
  assign chain_ena    = r_chain_ena;
  assign coef_pending = w_pending;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer (N=16, TAPS=4, SETTLE=1) against a 4-stage tapped-delay chain model.
module tb_fir_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        coef_wr = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        coef_commit = 1'b0;
  logic        coef_pending;
  logic        flush = 1'b0;
  logic [15:0] chain_x;
  logic        chain_ena;
  logic [63:0] chain_b;
  logic [15:0] chain_y;

  int n_vec = 0;
  int n_err = 0;
  int ena_cnt;
  int rises;
  int t;
  logic prev_ena;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;
  vec_t imp [5];

  localparam logic [63:0] B1234 = {16'd4, 16'd3, 16'd2, 16'd1};

  always #5 clk = ~clk;

  fir_sequencer #(.N(16), .TAPS(4), .SETTLE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .coef_wr      (coef_wr),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .coef_commit  (coef_commit),
    .coef_pending (coef_pending),
    .flush        (flush),
    .chain_x      (chain_x),
    .chain_ena    (chain_ena),
    .chain_b      (chain_b),
    .chain_y      (chain_y)
  );

  // Chain model: stage 0 sees chain_x directly, later stages see delayed samples.
  logic [15:0] d [3];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) d[i] <= '0;
    end else if (chain_ena) begin
      d[0] <= chain_x;
      d[1] <= d[0];
      d[2] <= d[1];
    end
  end
  assign chain_y = 16'(chain_b[15:0] * chain_x + chain_b[31:16] * d[0]
                     + chain_b[47:32] * d[1] + chain_b[63:48] * d[2]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input logic [63:0] b);
    for (int k = 0; k < 4; k++) begin
      coef_wr   = 1'b1;
      coef_addr = 3'(k);
      coef_data = b[k*16 +: 16];
      tick();
    end
    coef_wr     = 1'b0;
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    chk("commit pending", 64'(coef_pending), 64'(1));
    chk("commit blocks s_ready", 64'(s_ready), 64'(0));
    tick();
    chk("commit applied", chain_b, b);
    chk("pending cleared", 64'(coef_pending), 64'(0));
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input string name);
    int w;
    w = 0;
    while (s_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk({name, " s_ready"}, 64'(s_ready), 64'(1));
    s_valid = 1'b1;
    s_data  = x;
    tick();
    s_valid = 1'b0;
    chk({name, " s_ready low after accept"}, 64'(s_ready), 64'(0));
    tick();
    chk({name, " capture ena"}, 64'(chain_ena), 64'(1));
    chk({name, " no early m_valid"}, 64'(m_valid), 64'(0));
    tick();
    chk({name, " m_valid"}, 64'(m_valid), 64'(1));
    chk({name, " m_data"}, 64'(m_data), 64'(y));
    chk({name, " ena after capture"}, 64'(chain_ena), 64'(0));
    if (m_ready) begin
      tick();
      chk({name, " m_valid drop"}, 64'(m_valid), 64'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    imp[0] = '{16'd1, 16'd1};
    imp[1] = '{16'd0, 16'd2};
    imp[2] = '{16'd0, 16'd3};
    imp[3] = '{16'd0, 16'd4};
    imp[4] = '{16'd0, 16'd0};

    // Reset state and release
    tick();
    tick();
    chk("rst s_ready", 64'(s_ready), 64'(0));
    chk("rst m_valid", 64'(m_valid), 64'(0));
    chk("rst m_data", 64'(m_data), 64'(0));
    chk("rst chain_ena", 64'(chain_ena), 64'(0));
    chk("rst chain_x", 64'(chain_x), 64'(0));
    chk("rst chain_b", chain_b, 64'(0));
    chk("rst coef_pending", 64'(coef_pending), 64'(0));
    rst = 1'b1;
    chk("release s_ready same cycle", 64'(s_ready), 64'(0));
    tick();
    chk("release s_ready next cycle", 64'(s_ready), 64'(1));

    // 1. Reset while holding a result in OUTPUT
    set_bank(B1234);
    m_ready = 1'b0;
    send(16'd7, 16'd7, "pre-reset");
    rst = 1'b0;
    #1;
    chk("midrst m_valid", 64'(m_valid), 64'(0));
    chk("midrst m_data", 64'(m_data), 64'(0));
    chk("midrst s_ready", 64'(s_ready), 64'(0));
    chk("midrst chain_x", 64'(chain_x), 64'(0));
    chk("midrst chain_b", chain_b, 64'(0));
    chk("midrst chain_ena", 64'(chain_ena), 64'(0));
    tick();
    rst = 1'b1;
    m_ready = 1'b1;
    tick();
    chk("midrst s_ready after release", 64'(s_ready), 64'(1));

    // 2. Impulse response
    set_bank(B1234);
    for (int i = 0; i < 5; i++) send(imp[i].x, imp[i].y, "impulse");

    // 3. Backpressure
    m_ready = 1'b0;
    send(16'd3, 16'd3, "backpressure");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp m_valid", 64'(m_valid), 64'(1));
      chk("bp m_data", 64'(m_data), 64'(3));
      chk("bp s_ready", 64'(s_ready), 64'(0));
      chk("bp chain_ena", 64'(chain_ena), 64'(0));
    end
    m_ready = 1'b1;
    tick();
    chk("bp release m_valid", 64'(m_valid), 64'(0));

    // 4. Commit during SETTLE: this result keeps old b0=1, next sample uses b0=10
    s_valid = 1'b1;
    s_data  = 16'd1;
    tick();
    s_valid     = 1'b0;
    coef_wr     = 1'b1;
    coef_addr   = 3'd0;
    coef_data   = 16'd10;
    coef_commit = 1'b1;
    tick();
    coef_wr     = 1'b0;
    coef_commit = 1'b0;
    chk("busy commit pending", 64'(coef_pending), 64'(1));
    chk("busy b0 unchanged", 64'(chain_b[15:0]), 64'(1));
    tick();
    chk("busy m_valid", 64'(m_valid), 64'(1));
    chk("busy m_data old b", 64'(m_data), 64'(7));
    tick();
    chk("busy idle s_ready held", 64'(s_ready), 64'(0));
    chk("busy still pending", 64'(coef_pending), 64'(1));
    tick();
    chk("busy pending applied", 64'(coef_pending), 64'(0));
    chk("busy b0 new", 64'(chain_b[15:0]), 64'(10));
    send(16'd1, 16'd21, "new-b sample");

    // 5. Flush drains history
    set_bank(B1234);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush pending s_ready", 64'(s_ready), 64'(0));
    prev_ena = 1'b0;
    ena_cnt  = 0;
    rises    = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (chain_ena) begin
        ena_cnt++;
        chk("flush chain_x", 64'(chain_x), 64'(0));
      end
      if (chain_ena && !prev_ena) rises++;
      prev_ena = chain_ena;
      chk("flush no m_valid", 64'(m_valid), 64'(0));
    end
    chk("flush ena cycles", 64'(ena_cnt), 64'(4));
    chk("flush ena runs", 64'(rises), 64'(1));
    send(16'd5, 16'd5, "post-flush");

    // 6a. Out-of-range coefficient index is ignored
    coef_wr   = 1'b1;
    coef_addr = 3'd4;
    coef_data = 16'h0055;
    tick();
    coef_wr     = 1'b0;
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    tick();
    chk("addr4 ignored", chain_b, B1234);

    // 6b. Wrap-around passes through unmodified
    set_bank({16'd0, 16'd0, 16'd0, 16'h7FFF});
    send(16'd2, 16'hFFFE, "wrap");

    // 6c. Commit and flush together: commit applied first, flush next cycle
    coef_wr     = 1'b1;
    coef_addr   = 3'd0;
    coef_data   = 16'd9;
    coef_commit = 1'b1;
    flush       = 1'b1;
    tick();
    coef_wr     = 1'b0;
    coef_commit = 1'b0;
    flush       = 1'b0;
    chk("cf pending", 64'(coef_pending), 64'(1));
    chk("cf s_ready", 64'(s_ready), 64'(0));
    chk("cf no ena yet", 64'(chain_ena), 64'(0));
    tick();
    chk("cf commit first", 64'(coef_pending), 64'(0));
    chk("cf b0 new", 64'(chain_b[15:0]), 64'(9));
    chk("cf ena during commit", 64'(chain_ena), 64'(0));
    tick();
    chk("cf flush starts", 64'(chain_ena), 64'(1));
    chk("cf flush chain_x", 64'(chain_x), 64'(0));
    t = 0;
    while (s_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("cf back to idle", 64'(s_ready), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
